alu_sequencer: RTL and testbench

Control stage directly upstream of the 5-bit mini ALU. Accepts one command at a time over a valid/ready handshake, reads two operands from a 4-entry register file, and drives the ALU's A/B/Op inputs. It captures the combinational result R, writes it back to the register file, and presents it downstream over a second valid/ready handshake. Load-immediate commands bypass the ALU.

---
 rtl/alu_pkg.sv | 62 ++++++
 rtl/alu_regfile.sv | 42 ++++
 rtl/alu_sequencer.sv | 132 +++++++++++++
 tb/tb_alu_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared widths, opcodes, FSM states and command record for the
//               mini-ALU sequencer slice.
// Revision    : 1.0
// ============================================================================
package alu_pkg;

    localparam int DATA_W = 5;
    localparam int OP_W   = 3;
    localparam int RA_W   = 2;
    localparam int NREGS  = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
    localparam logic [OP_W-1:0] OP_NOTA = 3'd2;
    localparam logic [OP_W-1:0] OP_NOTB = 3'd3;
    localparam logic [OP_W-1:0] OP_AND  = 3'd4;
    localparam logic [OP_W-1:0] OP_OR   = 3'd5;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd6;
    localparam logic [OP_W-1:0] OP_SHL  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              ld;
        logic [OP_W-1:0]   op;
        logic [RA_W-1:0]   rd;
        logic [RA_W-1:0]   rs1;
        logic [RA_W-1:0]   rs2;
        logic [DATA_W-1:0] imm;
    } cmd_t;

    // Behaviour of the downstream ALU, for integration-level reference.
    function automatic logic [DATA_W-1:0] alu_eval(
        input logic [OP_W-1:0]   op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_NOTA: r = ~a;
            OP_NOTB: r = ~b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SHL:  r = {b[DATA_W-2:0], 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : alu_regfile
// Description : Small register file, two combinational read ports and one
//               synchronous write port, synchronously cleared.
// Revision    : 1.0
// ============================================================================
module alu_regfile
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = NREGS,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata_a = r_mem[raddr_a];
    assign rdata_b = r_mem[raddr_b];

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : One-command-at-a-time control stage driving an external 5-bit
//               ALU, with register-file write-back and a result handshake.
// Revision    : 1.0
// ============================================================================
module alu_sequencer
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_ld,
    input  logic [OP_W-1:0]   in_op,
    input  logic [RA_W-1:0]   in_rd,
    input  logic [RA_W-1:0]   in_rs1,
    input  logic [RA_W-1:0]   in_rs2,
    input  logic [DATA_W-1:0] in_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_r,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RA_W-1:0]   out_rd,
    output logic [7:0]        op_count
);

    state_t            r_state;
    state_t            w_next;
    cmd_t              r_cmd;
    logic [DATA_W-1:0] r_out_data;
    logic [RA_W-1:0]   r_out_rd;
    logic [7:0]        r_op_count;
    logic [DATA_W-1:0] w_rs1_data;
    logic [DATA_W-1:0] w_rs2_data;
    logic [DATA_W-1:0] w_result;
    logic              w_exec;
    logic              w_accept;
    logic              w_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_exec    = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = '0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = EXEC;
                end
            end
            EXEC: begin
                w_exec = 1'b1;
                alu_a  = w_rs1_data;
                alu_b  = w_rs2_data;
                alu_op = r_cmd.op;
                w_next = RESP;
            end
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_accept = in_valid && in_ready;
    assign w_done   = out_valid && out_ready;
    assign w_result = r_cmd.ld ? r_cmd.imm : alu_r;

    // Operands are read before the write lands, so rd may alias rs1/rs2.
    alu_regfile #(
        .WIDTH (DATA_W),
        .DEPTH (NREGS),
        .AW    (RA_W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (w_exec && !rst),
        .waddr   (r_cmd.rd),
        .wdata   (w_result),
        .raddr_a (r_cmd.rs1),
        .rdata_a (w_rs1_data),
        .raddr_b (r_cmd.rs2),
        .rdata_b (w_rs2_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd      <= '0;
            r_out_data <= '0;
            r_out_rd   <= '0;
            r_op_count <= '0;
        end else begin
            if (w_accept) begin
                r_cmd <= '{ld: in_ld, op: in_op, rd: in_rd, rs1: in_rs1,
                           rs2: in_rs2, imm: in_imm};
            end
            if (w_exec) begin
                r_out_data <= w_result;
                r_out_rd   <= r_cmd.rd;
            end
            if (w_done) begin
                r_op_count <= r_op_count + 8'd1;
            end
        end
    end

    assign out_data = r_out_data;
    assign out_rd   = r_out_rd;
    assign op_count = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Scoreboard bench for alu_sequencer with an abstract ALU and
//               register-file model; includes the ALU stand-in.
// Revision    : 1.0
// ============================================================================
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_ld;
    logic [2:0] in_op;
    logic [1:0] in_rd;
    logic [1:0] in_rs1;
    logic [1:0] in_rs2;
    logic [4:0] in_imm;
    logic [4:0] alu_a;
    logic [4:0] alu_b;
    logic [2:0] alu_op;
    logic [4:0] alu_r;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_data;
    logic [1:0] out_rd;
    logic [7:0] op_count;

    typedef struct {
        int rd;
        int data;
    } exp_t;

    exp_t       sb[$];
    int         mregs[4];
    int         exp_a;
    int         exp_b;
    int         exp_op;
    logic [7:0] exp_count;
    int         mode;
    int         n_tests;
    int         n_fail;

    always #5 clk = ~clk;

    function automatic int ref_alu(input int op, input int a, input int b);
        int r;
        case (op)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = ~a;
            3:       r = ~b;
            4:       r = a & b;
            5:       r = a | b;
            6:       r = a ^ b;
            default: r = b * 2;
        endcase
        return r & 31;
    endfunction

    assign alu_r = 5'(ref_alu(int'(alu_op), int'(alu_a), int'(alu_b)));

    alu_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ld     (in_ld),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_r     (alu_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .op_count  (op_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic send(input bit ld, input int op, input int rd, input int rs1,
                        input int rs2, input int imm, input bit expect_resp,
                        output int waits);
        int a;
        int b;
        int res;
        @(negedge clk);
        in_valid = 1'b1;
        in_ld    = ld;
        in_op    = 3'(op);
        in_rd    = 2'(rd);
        in_rs1   = 2'(rs1);
        in_rs2   = 2'(rs2);
        in_imm   = 5'(imm);
        waits    = 0;
        while (!in_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(waits), 32'd0);
            in_valid = 1'b0;
        end else begin
            a      = mregs[rs1];
            b      = mregs[rs2];
            exp_a  = a;
            exp_b  = b;
            exp_op = op;
            res    = ld ? imm : ref_alu(op, a, b);
            if (expect_resp) begin
                mregs[rd] = res;
                sb.push_back('{rd: rd, data: res});
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sb.size() == 0 && in_ready && !out_valid) && n < budget);
        if (n >= budget) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int w;
        n_tests   = 0;
        n_fail    = 0;
        exp_count = 8'd0;
        mode      = 2;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_ld     = 1'b0;
        in_op     = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_imm    = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) mregs[i] = 0;

        fork
            // out_ready driver: 0 = random, 1 = always, 2 = held low
            forever begin
                @(posedge clk);
                #2;
                if (mode == 1)      out_ready = 1'b1;
                else if (mode == 2) out_ready = 1'b0;
                else                out_ready = ($urandom_range(0, 3) != 0);
            end
            // monitor / scoreboard
            begin
                bit         held;
                logic [4:0] hold_data;
                logic [1:0] hold_rd;
                exp_t       e;
                held = 1'b0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        exp_count = 8'd0;
                        sb.delete();
                        held = 1'b0;
                    end else begin
                        chk("op_count", 32'(op_count), 32'(exp_count));
                        if (held && !out_valid) chk("hold_valid", 32'(out_valid), 32'd1);
                        if (out_valid) begin
                            chk("in_ready_resp", 32'(in_ready), 32'd0);
                            chk("alu_idle_resp", {alu_a, alu_b, alu_op}, 32'd0);
                            if (held) begin
                                chk("hold_data", 32'(out_data), 32'(hold_data));
                                chk("hold_rd", 32'(out_rd), 32'(hold_rd));
                            end
                            if (out_ready) begin
                                held = 1'b0;
                                if (sb.size() == 0) begin
                                    chk("unexpected_result", 32'(out_data), 32'hFFFF_FFFF);
                                end else begin
                                    e = sb.pop_front();
                                    chk("out_data", 32'(out_data), 32'(e.data));
                                    chk("out_rd", 32'(out_rd), 32'(e.rd));
                                end
                                exp_count = exp_count + 8'd1;
                            end else begin
                                held      = 1'b1;
                                hold_data = out_data;
                                hold_rd   = out_rd;
                            end
                        end else if (!in_ready) begin
                            chk("alu_a_exec", 32'(alu_a), 32'(exp_a));
                            chk("alu_b_exec", 32'(alu_b), 32'(exp_b));
                            chk("alu_op_exec", 32'(alu_op), 32'(exp_op));
                        end else begin
                            chk("alu_idle", {alu_a, alu_b, alu_op}, 32'd0);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_alu", {alu_a, alu_b, alu_op}, 32'd0);

        // loads, then ALU ops on r1=5, r2=3
        mode = 1;
        send(1, 0, 1, 0, 0, 5, 1, w);
        send(1, 0, 2, 0, 0, 3, 1, w);
        wait_idle(50);
        chk("count_after_loads", 32'(op_count), 32'd2);
        send(0, 0, 0, 1, 2, 0, 1, w);
        send(0, 1, 3, 2, 1, 0, 1, w);
        send(0, 2, 0, 1, 0, 0, 1, w);
        send(0, 7, 3, 0, 2, 0, 1, w);
        wait_idle(50);

        // aliasing: r1 = r1 + r1, then read r1 back
        send(1, 0, 1, 0, 0, 20, 1, w);
        send(0, 0, 1, 1, 1, 0, 1, w);
        send(0, 5, 0, 1, 1, 0, 1, w);
        wait_idle(50);

        // backpressure with a waiting upstream command
        mode = 2;
        send(1, 0, 3, 0, 0, 17, 1, w);
        in_valid = 1'b1;
        in_ld    = 1'b0;
        in_op    = 3'd6;
        in_rd    = 2'd2;
        in_rs1   = 2'd3;
        in_rs2   = 2'd1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        mode = 1;
        send(0, 6, 2, 3, 1, 0, 1, w);
        chk("bp_accept_delay", 32'(w), 32'd1);
        wait_idle(50);

        // reset while the ADD is in EXEC
        send(0, 0, 2, 1, 1, 0, 0, w);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) mregs[i] = 0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_op_count", 32'(op_count), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        send(0, 0, 3, 2, 2, 0, 1, w);

        // 256 handshakes since reset wrap the counter
        for (int i = 0; i < 255; i++) begin
            send(1, 0, int'($urandom_range(0, 3)), 0, 0, int'($urandom_range(0, 31)), 1, w);
        end
        wait_idle(50);
        chk("wrap_256", 32'(op_count), 32'd0);
        send(1, 0, 0, 0, 0, 9, 1, w);
        wait_idle(50);
        chk("wrap_257", 32'(op_count), 32'd1);

        // randomized commands under random backpressure
        mode = 0;
        for (int i = 0; i < 80; i++) begin
            send(bit'($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), 1, w);
        end
        wait_idle(400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
